// File: rtl/mdu_issue_controller.sv
// Issue controller between execute and the MDU: queues HI/LO writes and mul/div starts
// in order, serves HI/LO reads combinationally. Optional counters under MDU_ISSUE_STATS_EN.
module mdu_issue_controller #(
  parameter int QUEUE_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  input  logic [2:0]  reqOperation,
  input  logic [31:0] reqOperand1,
  input  logic [31:0] reqOperand2,
  output logic        reqReady,
  output logic [31:0] respData,
  output logic [2:0]  mduOperation,
  output logic [31:0] mduOperand1,
  output logic [31:0] mduOperand2,
  output logic        mduStart,
  input  logic        mduBusy,
`ifdef MDU_ISSUE_STATS_EN
  output logic [31:0] statStallCycles,
  output logic [31:0] statIssued,
`endif
  input  logic [31:0] mduDataRead
);

  typedef enum logic [2:0] {
    OP_READ_HI  = 3'd0,
    OP_READ_LO  = 3'd1,
    OP_WRITE_HI = 3'd2,
    OP_WRITE_LO = 3'd3,
    OP_SMUL     = 3'd4,
    OP_UMUL     = 3'd5,
    OP_SDIV     = 3'd6,
    OP_UDIV     = 3'd7
  } mdu_operation_t;

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  logic [2:0]       q_op  [QUEUE_DEPTH];
  logic [31:0]      q_op1 [QUEUE_DEPTH];
  logic [31:0]      q_op2 [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic full;
  logic empty;
  logic is_read;
  logic enq;
  logic issue;
  logic read_ok;
  logic [2:0] head_op;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(QUEUE_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(QUEUE_DEPTH));
  assign empty   = (count == '0);
  assign is_read = (reqOperation == OP_READ_HI) || (reqOperation == OP_READ_LO);
  assign head_op = q_op[rd_ptr];

  // Handshake: a request transfers on a cycle where reqValid && reqReady. Writes/starts
  // need a free slot (a same-cycle pop does not count); reads need an empty queue and an
  // idle MDU, and their data is returned in that same cycle.
  assign enq     = reqValid && !is_read && !full;
  assign issue   = !empty && !mduBusy;
  assign read_ok = reqValid && is_read && empty && !mduBusy;

  always_comb begin
    reqReady     = 1'b0;
    respData     = '0;
    mduOperation = OP_READ_HI;
    mduOperand1  = '0;
    mduOperand2  = '0;
    mduStart     = 1'b0;
    if (!reset) begin
      reqReady = is_read ? (empty && !mduBusy) : !full;
      if (issue) begin
        mduOperation = head_op;
        mduOperand1  = q_op1[rd_ptr];
        mduOperand2  = q_op2[rd_ptr];
        mduStart     = head_op[2];
      end else if (read_ok) begin
        mduOperation = reqOperation;
        respData     = mduDataRead;
      end
    end
  end

  // Entry storage carries no reset; only the occupancy state defines validity.
  always_ff @(posedge clock) begin
    if (!reset && enq) begin
      q_op[wr_ptr]  <= reqOperation;
      q_op1[wr_ptr] <= reqOperand1;
      q_op2[wr_ptr] <= reqOperand2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq)   wr_ptr <= ptr_inc(wr_ptr);
      if (issue) rd_ptr <= ptr_inc(rd_ptr);
      case ({enq, issue})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef MDU_ISSUE_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      statStallCycles <= '0;
      statIssued      <= '0;
    end else begin
      if (reqValid && !reqReady) statStallCycles <= statStallCycles + 32'd1;
      if (mduStart)              statIssued      <= statIssued + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mdu_issue_controller.sv
// Directed table-driven bench for mdu_issue_controller with a small behavioural MDU
// (3-cycle busy, MIPS HI/LO semantics). Stats checks compile under MDU_ISSUE_STATS_EN.
module tb_mdu_issue_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        reqValid = 1'b0;
  logic [2:0]  reqOperation = 3'd0;
  logic [31:0] reqOperand1 = '0;
  logic [31:0] reqOperand2 = '0;
  logic        reqReady;
  logic [31:0] respData;
  logic [2:0]  mduOperation;
  logic [31:0] mduOperand1;
  logic [31:0] mduOperand2;
  logic        mduStart;
  logic        mdl_busy;
  logic [31:0] mdl_rd;
`ifdef MDU_ISSUE_STATS_EN
  logic [31:0] stat_stall;
  logic [31:0] stat_issued;
`endif

  int checks = 0;
  int failures = 0;

  // ---------------- clock/reset ----------------
  always #5 clock = ~clock;

  mdu_issue_controller #(.QUEUE_DEPTH(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .reqValid     (reqValid),
    .reqOperation (reqOperation),
    .reqOperand1  (reqOperand1),
    .reqOperand2  (reqOperand2),
    .reqReady     (reqReady),
    .respData     (respData),
    .mduOperation (mduOperation),
    .mduOperand1  (mduOperand1),
    .mduOperand2  (mduOperand2),
    .mduStart     (mduStart),
    .mduBusy      (mdl_busy),
`ifdef MDU_ISSUE_STATS_EN
    .statStallCycles (stat_stall),
    .statIssued      (stat_issued),
`endif
    .mduDataRead  (mdl_rd)
  );

  // ---------------- behavioural MDU ----------------
  logic [31:0] hi, lo, p_hi, p_lo, res_hi, res_lo;
  logic [63:0] prod;
  logic [1:0]  mdl_cnt;

  assign mdl_rd = (mduOperation == 3'd1) ? lo : hi;

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    prod   = '0;
    case (mduOperation)
      3'd4: begin
        prod   = {{32{mduOperand1[31]}}, mduOperand1} * {{32{mduOperand2[31]}}, mduOperand2};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      3'd5: begin
        prod   = {32'b0, mduOperand1} * {32'b0, mduOperand2};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      3'd6: if (mduOperand2 != 0) begin
        res_lo = $signed(mduOperand1) / $signed(mduOperand2);
        res_hi = $signed(mduOperand1) % $signed(mduOperand2);
      end
      3'd7: if (mduOperand2 != 0) begin
        res_lo = mduOperand1 / mduOperand2;
        res_hi = mduOperand1 % mduOperand2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mdl_busy <= 1'b0;
      mdl_cnt  <= '0;
      hi <= '0; lo <= '0; p_hi <= '0; p_lo <= '0;
    end else if (mduStart) begin
      mdl_busy <= 1'b1;
      mdl_cnt  <= 2'd3;
      p_hi <= res_hi;
      p_lo <= res_lo;
    end else if (mdl_busy) begin
      mdl_cnt <= mdl_cnt - 2'd1;
      if (mdl_cnt == 2'd1) begin
        mdl_busy <= 1'b0;
        hi <= p_hi;
        lo <= p_lo;
      end
    end else if (mduOperation == 3'd2) begin
      hi <= mduOperand1;
    end else if (mduOperation == 3'd3) begin
      lo <= mduOperand1;
    end
  end

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic        rst;
    logic        valid;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rdy;
    logic [2:0]  mop;
    logic [31:0] m1;
    logic [31:0] m2;
    logic        st;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];

  function automatic void add(logic rst, logic valid, logic [2:0] op, logic [31:0] a,
                              logic [31:0] b, logic rdy, logic [2:0] mop, logic [31:0] m1,
                              logic [31:0] m2, logic st);
    vec_t v;
    v.rst = rst; v.valid = valid; v.op = op; v.a = a; v.b = b;
    v.rdy = rdy; v.mop = mop; v.m1 = m1; v.m2 = m2; v.st = st;
    tbl.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(string tag, int idx, vec_t v);
    logic is_rd;
    @(negedge clock);
    reset        = v.rst;
    reqValid     = v.valid;
    reqOperation = v.op;
    reqOperand1  = v.a;
    reqOperand2  = v.b;
    #1;
    is_rd = v.valid && !v.rst && (v.op[2:1] == 2'b00);
    if (v.valid) chk($sformatf("%s[%0d].ready", tag, idx), 32'(reqReady), 32'(v.rdy));
    if (is_rd && v.rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s[%0d].resp actual=%h expected=none_queued", tag, idx, respData);
      end else begin
        chk($sformatf("%s[%0d].resp", tag, idx), respData, exp_q.pop_front());
      end
    end else begin
      chk($sformatf("%s[%0d].resp_idle", tag, idx), respData, 32'd0);
    end
    chk($sformatf("%s[%0d].mop", tag, idx), 32'(mduOperation), 32'(v.mop));
    chk($sformatf("%s[%0d].m1", tag, idx), mduOperand1, v.m1);
    chk($sformatf("%s[%0d].m2", tag, idx), mduOperand2, v.m2);
    chk($sformatf("%s[%0d].start", tag, idx), 32'(mduStart), 32'(v.st));
  endtask

  task automatic run_tbl(string tag);
    foreach (tbl[i]) step(tag, i, tbl[i]);
    chk({tag, ".reads_left"}, 32'(exp_q.size()), 32'd0);
    tbl.delete();
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    // reset held with a read pending, then 5 idle cycles, then reads of cleared HI/LO
    add(1'b1, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b1, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++)
      add(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd1, 32'd0, 32'd0, 1'b1, 3'd1, 32'd0, 32'd0, 1'b0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    run_tbl("reset_idle");

    // SMUL -3*7 then READ_LO stalls through the busy window
    add(1'b0, 1'b1, 3'd4, 32'hFFFFFFFD, 32'd7, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd1, 32'd0, 32'd0, 1'b0, 3'd4, 32'hFFFFFFFD, 32'd7, 1'b1);
    for (int i = 0; i < 3; i++)
      add(1'b0, 1'b1, 3'd1, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd1, 32'd0, 32'd0, 1'b1, 3'd1, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
    exp_q.push_back(32'hFFFFFFEB);
    exp_q.push_back(32'hFFFFFFFF);
    run_tbl("smul_read");

    // back-to-back SMUL, UMUL, UDIV, WRITE_HI: queue fills, drains in order
    add(1'b0, 1'b1, 3'd4, 32'd2, 32'd3, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd5, 32'd6, 32'd7, 1'b1, 3'd4, 32'd2, 32'd3, 1'b1);
    add(1'b0, 1'b1, 3'd7, 32'd100, 32'd7, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd2, 32'd5, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd2, 32'd5, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd2, 32'd5, 32'd0, 1'b0, 3'd5, 32'd6, 32'd7, 1'b1);
    add(1'b0, 1'b1, 3'd2, 32'd5, 32'd0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0, 3'd7, 32'd100, 32'd7, 1'b1);
    for (int i = 0; i < 3; i++)
      add(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0, 3'd2, 32'd5, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd1, 32'd0, 32'd0, 1'b1, 3'd1, 32'd0, 32'd0, 1'b0);
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd14);
    run_tbl("queue_full");

    // WRITE_LO then READ_LO: read waits exactly for the write to issue
    add(1'b0, 1'b1, 3'd3, 32'h1234, 32'd0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd1, 32'd0, 32'd0, 1'b0, 3'd3, 32'h1234, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd1, 32'd0, 32'd0, 1'b1, 3'd1, 32'd0, 32'd0, 1'b0);
    exp_q.push_back(32'h1234);
    run_tbl("write_read");

    // reset with two queued entries and the MDU busy discards everything
    add(1'b0, 1'b1, 3'd4, 32'd1, 32'd1, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd5, 32'd2, 32'd2, 1'b1, 3'd4, 32'd1, 32'd1, 1'b1);
    add(1'b0, 1'b1, 3'd6, 32'd9, 32'd2, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd3, 32'd8, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b1, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd1, 32'd0, 32'd0, 1'b1, 3'd1, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    exp_q.push_back(32'd0);
    run_tbl("mid_reset");

    // SDIV -7/2 then READ_HI: remainder -1 after four stall cycles
    add(1'b0, 1'b1, 3'd6, 32'hFFFFFFF9, 32'd2, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0, 3'd6, 32'hFFFFFFF9, 32'd2, 1'b1);
    for (int i = 0; i < 3; i++)
      add(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
    add(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    exp_q.push_back(32'hFFFFFFFF);
    run_tbl("sdiv_read");

`ifdef MDU_ISSUE_STATS_EN
    chk("stat_issued", stat_issued, 32'd1);
    chk("stat_stall", stat_stall, 32'd4);
`endif

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
